// File: rtl/sc_colision_pkg.sv
// Shared definitions for the per-lane collision checker and the game-state machine.
package sc_colision_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_HIT   = 3'd2,
    ST_GRACE = 3'd3,
    ST_OVER  = 3'd4
  } colision_state_t;

  // Game-state code during which collisions are evaluated.
  localparam logic [2:0] SC_ESTADO_PLAY = 3'b010;

endpackage

// File: rtl/sc_colision_grace_cnt.sv
// Invulnerability-window counter: synchronous clear, count enable, terminal-count flag.
module sc_colision_grace_cnt #(
  parameter int GRACE_DATAWIDTH = 4
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       clear,
  input  logic                       enable,
  output logic [GRACE_DATAWIDTH-1:0] count,
  output logic                       tc
);

  logic [GRACE_DATAWIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign tc    = &count_reg;

endmodule

// File: rtl/sc_colision_nv.sv
// Per-lane collision checker: detects frog/vehicle overlap during play, pulses a hit,
// tracks lives, and sequences the grace window and game-over.
module sc_colision_nv
  import sc_colision_pkg::*;
#(
  parameter int                          DATAWIDTH_BUS    = 8,
  parameter int                          DATAWIDTH_ESTADO = 3,
  parameter logic [DATAWIDTH_ESTADO-1:0] ESTADO_PLAY      = SC_ESTADO_PLAY,
  parameter int                          DATAWIDTH_LIVES  = 2,
  parameter int                          INIT_LIVES       = 3,
  parameter int                          GRACE_DATAWIDTH  = 4,
  parameter int                          BLINK_BIT        = 1
) (
  input  logic                        SC_COLISION_NV_CLOCK_50,
  input  logic                        SC_COLISION_NV_RESET,
  input  logic [DATAWIDTH_BUS-1:0]    SC_COLISION_NV_LANE_IN,
  input  logic [DATAWIDTH_BUS-1:0]    SC_COLISION_NV_FROG_COL_IN,
  input  logic                        SC_COLISION_NV_FROG_IN_LANE_IN,
  input  logic [DATAWIDTH_ESTADO-1:0] SC_COLISION_NV_ESTADO_IN,
  input  logic                        SC_COLISION_NV_RESTART_IN,
  output logic                        SC_COLISION_NV_HIT_OUT,
  output logic [DATAWIDTH_LIVES-1:0]  SC_COLISION_NV_LIVES_OUT,
  output logic                        SC_COLISION_NV_GRACE_OUT,
  output logic                        SC_COLISION_NV_BLINK_OUT,
  output logic                        SC_COLISION_NV_GAMEOVER_OUT
);

  localparam logic [DATAWIDTH_LIVES-1:0] LIVES_INIT = DATAWIDTH_LIVES'(INIT_LIVES);

  colision_state_t              state_reg;
  logic [DATAWIDTH_LIVES-1:0]   lives_reg;
  logic                         hit_reg;
  logic                         grace_reg;
  logic                         gameover_reg;
  logic                         overlap;
  logic                         play;
  logic                         grace_clear;
  logic                         grace_tc;
  logic [GRACE_DATAWIDTH-1:0]   grace_count;

  assign overlap = SC_COLISION_NV_FROG_IN_LANE_IN &
                   (|(SC_COLISION_NV_LANE_IN & SC_COLISION_NV_FROG_COL_IN));
  assign play    = (SC_COLISION_NV_ESTADO_IN == ESTADO_PLAY);

  // Counter sits at zero outside GRACE, so it always restarts the window from zero
  // and the blink tap is low whenever the frog is not invulnerable.
  assign grace_clear = (state_reg != ST_GRACE) || !play;

  sc_colision_grace_cnt #(
    .GRACE_DATAWIDTH(GRACE_DATAWIDTH)
  ) u_grace_cnt (
    .clk    (SC_COLISION_NV_CLOCK_50),
    .srst   (SC_COLISION_NV_RESET),
    .clear  (grace_clear),
    .enable (state_reg == ST_GRACE),
    .count  (grace_count),
    .tc     (grace_tc)
  );

  always_ff @(posedge SC_COLISION_NV_CLOCK_50) begin
    if (SC_COLISION_NV_RESET) begin
      state_reg    <= ST_IDLE;
      lives_reg    <= LIVES_INIT;
      hit_reg      <= 1'b0;
      grace_reg    <= 1'b0;
      gameover_reg <= 1'b0;
    end else begin
      hit_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (play) begin
            state_reg <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!play) begin
            state_reg <= ST_IDLE;
          end else if (overlap && (lives_reg != '0)) begin
            // Decrement here so the new count appears alongside the hit pulse.
            state_reg <= ST_HIT;
            lives_reg <= lives_reg - 1'b1;
            hit_reg   <= 1'b1;
          end
        end
        ST_HIT: begin
          if (lives_reg == '0) begin
            state_reg    <= ST_OVER;
            gameover_reg <= 1'b1;
          end else begin
            state_reg <= ST_GRACE;
            grace_reg <= 1'b1;
          end
        end
        ST_GRACE: begin
          if (!play) begin
            state_reg <= ST_IDLE;
            grace_reg <= 1'b0;
          end else if (grace_tc) begin
            state_reg <= ST_ARMED;
            grace_reg <= 1'b0;
          end
        end
        ST_OVER: begin
          if (SC_COLISION_NV_RESTART_IN) begin
            state_reg    <= ST_IDLE;
            lives_reg    <= LIVES_INIT;
            gameover_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          grace_reg    <= 1'b0;
          gameover_reg <= 1'b0;
        end
      endcase
    end
  end

  assign SC_COLISION_NV_HIT_OUT      = hit_reg;
  assign SC_COLISION_NV_LIVES_OUT    = lives_reg;
  assign SC_COLISION_NV_GRACE_OUT    = grace_reg;
  assign SC_COLISION_NV_BLINK_OUT    = grace_count[BLINK_BIT];
  assign SC_COLISION_NV_GAMEOVER_OUT = gameover_reg;

endmodule
